reg_bank_reader: RTL and testbench

Read side of the 4-bit register bank used by the irrigation/sensor control path. On a `start` request it snapshots all bank words in one cycle, then delivers them one at a time as (address, data) pairs over a valid/ready handshake to the downstream consumer (display/telemetry). An optional changed-only mode suppresses words equal to the value delivered on the previous scan.

---
 rtl/reg_bank_pkg.sv | 24 ++
 rtl/reg_bank_snap.sv | 56 +++++
 rtl/reg_bank_reader.sv | 154 +++++++++++++++
 tb/tb_reg_bank_reader.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_bank_pkg.sv
// Shared definitions for the register-bank read path: FSM state encoding,
// default bank geometry and the address-width helper.
package reg_bank_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SNAP = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam int N_REGS_DEF = 4;
  localparam int W_DEF      = 4;

  // Width of a word index; never narrower than one bit.
  function automatic int addr_width(input int n);
    if (n < 2) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/reg_bank_snap.sv
// Snapshot and last-delivered word storage for the bank reader, with the
// equality compares the FSM uses to decide whether a word is skipped.
module reg_bank_snap
  import reg_bank_pkg::*;
#(
  parameter int N_REGS = N_REGS_DEF,
  parameter int W      = W_DEF,
  parameter int AW     = addr_width(N_REGS)
) (
  input  logic                C,
  input  logic                Clr,
  input  logic                cap,
  input  logic [N_REGS*W-1:0] bank_q,
  input  logic                wr,
  input  logic [AW-1:0]       wr_idx,
  input  logic [AW-1:0]       rd_idx,
  output logic [W-1:0]        rd_word,
  output logic                rd_eq,
  output logic                cap_eq0
);

  logic [W-1:0] snap_r [N_REGS];
  logic [W-1:0] last_r [N_REGS];

  // Capture the whole bank in one cycle so later bank changes cannot leak into a scan.
  always_ff @(posedge C) begin
    if (Clr) begin
      for (int i = 0; i < N_REGS; i++) begin
        snap_r[i] <= '0;
      end
    end else if (cap) begin
      for (int i = 0; i < N_REGS; i++) begin
        snap_r[i] <= bank_q[i*W +: W];
      end
    end
  end

  // Remember the value actually handed to the consumer, per word; reset forgets history.
  always_ff @(posedge C) begin
    if (Clr) begin
      for (int i = 0; i < N_REGS; i++) begin
        last_r[i] <= '0;
      end
    end else if (wr) begin
      last_r[wr_idx] <= snap_r[wr_idx];
    end
  end

  // Look-ahead read of the word the FSM will present next, plus the skip compares.
  always_comb begin
    rd_word = snap_r[rd_idx];
    rd_eq   = (snap_r[rd_idx] == last_r[rd_idx]);
    cap_eq0 = (bank_q[W-1:0] == last_r[0]);
  end

endmodule

// File: rtl/reg_bank_reader.sv
// Read side of the register bank: on start, snapshot every word and stream
// them out as (address, data) pairs over valid/ready, optionally dropping
// words that have not changed since they were last delivered.
module reg_bank_reader
  import reg_bank_pkg::*;
#(
  parameter int N_REGS = N_REGS_DEF,
  parameter int W      = W_DEF,
  localparam int AW    = addr_width(N_REGS)
) (
  input  logic                C,
  input  logic                Clr,
  input  logic                CE,
  input  logic                start,
  input  logic                changed_only,
  input  logic [N_REGS*W-1:0] bank_q,
  input  logic                ready,
  output logic                valid,
  output logic [W-1:0]        data_out,
  output logic [AW-1:0]       addr_out,
  output logic                busy,
  output logic                done
);

  localparam logic [AW-1:0] LAST_IDX = AW'(N_REGS - 1);

  state_e        state_r;
  logic [AW-1:0] idx_r;
  logic          mode_r;
  logic          first_scan_r;
  logic          valid_r;
  logic [W-1:0]  data_r;
  logic [AW-1:0] addr_r;
  logic          busy_r;
  logic          done_r;

  logic          last_idx_s;
  logic [AW-1:0] nxt_idx_s;
  logic          advance_s;
  logic          cap_s;
  logic          wr_s;
  logic          snap_skip_s;
  logic          next_skip_s;
  logic [W-1:0]  rd_word_s;
  logic          rd_eq_s;
  logic          cap_eq0_s;

  reg_bank_snap #(
    .N_REGS (N_REGS),
    .W      (W),
    .AW     (AW)
  ) u_snap (
    .C       (C),
    .Clr     (Clr),
    .cap     (cap_s),
    .bank_q  (bank_q),
    .wr      (wr_s),
    .wr_idx  (idx_r),
    .rd_idx  (nxt_idx_s),
    .rd_word (rd_word_s),
    .rd_eq   (rd_eq_s),
    .cap_eq0 (cap_eq0_s)
  );

  // Step decisions: a presented word advances on ready, a skipped word (valid low) always advances.
  // The skip decision for the upcoming word is made one cycle early so valid can be a flop.
  always_comb begin
    last_idx_s = (idx_r == LAST_IDX);
    if (last_idx_s) begin
      nxt_idx_s = '0;
    end else begin
      nxt_idx_s = idx_r + AW'(1);
    end
    if (valid_r) begin
      advance_s = ready;
    end else begin
      advance_s = 1'b1;
    end
    cap_s       = CE & (state_r == SNAP);
    wr_s        = CE & (state_r == SEND) & valid_r & ready;
    snap_skip_s = changed_only & ~first_scan_r & cap_eq0_s;
    next_skip_s = mode_r & ~first_scan_r & rd_eq_s;
  end

  // Scan sequencer with all consumer-facing outputs held in flops.
  always_ff @(posedge C) begin
    if (Clr) begin
      state_r      <= IDLE;
      idx_r        <= '0;
      mode_r       <= 1'b0;
      first_scan_r <= 1'b1;
      valid_r      <= 1'b0;
      data_r       <= '0;
      addr_r       <= '0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
    end else if (CE) begin
      case (state_r)
        IDLE: begin
          valid_r <= 1'b0;
          done_r  <= 1'b0;
          if (start) begin
            state_r <= SNAP;
            busy_r  <= 1'b1;
          end else begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end
        end
        SNAP: begin
          state_r <= SEND;
          idx_r   <= '0;
          mode_r  <= changed_only;
          valid_r <= ~snap_skip_s;
          data_r  <= bank_q[W-1:0];
          addr_r  <= '0;
        end
        SEND: begin
          if (advance_s) begin
            if (last_idx_s) begin
              state_r <= DONE;
              valid_r <= 1'b0;
              done_r  <= 1'b1;
            end else begin
              idx_r   <= nxt_idx_s;
              valid_r <= ~next_skip_s;
              data_r  <= rd_word_s;
              addr_r  <= nxt_idx_s;
            end
          end
        end
        DONE: begin
          state_r      <= IDLE;
          done_r       <= 1'b0;
          busy_r       <= 1'b0;
          first_scan_r <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          valid_r <= 1'b0;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign valid    = valid_r;
  assign data_out = data_r;
  assign addr_out = addr_r;
  assign busy     = busy_r;
  assign done     = done_r;

endmodule

// File: tb/tb_reg_bank_reader.sv
// Self-checking bench for reg_bank_reader: scans are predicted by a simple
// per-word model into a queue; a monitor pops and compares on every transfer.
module tb_reg_bank_reader;

  localparam int N  = 4;
  localparam int W  = 4;
  localparam int AW = 2;

  logic          C = 1'b0;
  logic          Clr = 1'b1;
  logic          CE;
  logic          start = 1'b0;
  logic          changed_only = 1'b0;
  logic [N*W-1:0] bank_q = '0;
  logic          ready = 1'b1;
  logic          valid;
  logic [W-1:0]  data_out;
  logic [AW-1:0] addr_out;
  logic          busy;
  logic          done;

  int tests = 0;
  int fails = 0;
  int xfers = 0;
  int done_cnt = 0;
  int ready_mode = 0;
  int rcyc = 0;
  bit ce_plan = 1'b0;

  logic [AW+W-1:0] exp_q[$];
  logic [W-1:0]    last_m[N];
  bit              first_m;
  bit              hold_chk = 1'b0;
  logic [AW+W-1:0] prev_w = '0;

  reg_bank_reader #(.N_REGS(N), .W(W)) dut (
    .C            (C),
    .Clr          (Clr),
    .CE           (CE),
    .start        (start),
    .changed_only (changed_only),
    .bank_q       (bank_q),
    .ready        (ready),
    .valid        (valid),
    .data_out     (data_out),
    .addr_out     (addr_out),
    .busy         (busy),
    .done         (done)
  );

  always #5 C = ~C;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: which words a scan of bank b in the given mode must deliver.
  task automatic model_scan(input logic [N*W-1:0] b, input bit mode);
    logic [W-1:0] w;
    for (int i = 0; i < N; i++) begin
      w = b[i*W +: W];
      if (!(mode && !first_m && (w == last_m[i]))) begin
        exp_q.push_back({AW'(i), w});
        last_m[i] = w;
      end
    end
    first_m = 1'b0;
  endtask

  task automatic model_reset();
    first_m = 1'b1;
    for (int i = 0; i < N; i++) last_m[i] = '0;
    exp_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_data"}, data_out, 0);
    check({tag, "_addr"}, addr_out, 0);
  endtask

  task automatic wait_done(output int cnt);
    bit seen;
    seen = 1'b0;
    cnt = 0;
    while (!seen && cnt < 200) begin
      @(negedge C);
      cnt++;
      if (done) seen = 1'b1;
    end
    check("done_seen", seen, 1);
  endtask

  task automatic end_checks(input int x0, input int d0, input int exp_x);
    repeat (3) @(posedge C);
    @(negedge C);
    check("busy_after", busy, 0);
    check("done_after", done, 0);
    check("queue_empty", exp_q.size(), 0);
    check("done_pulses", done_cnt - d0, 1);
    if (exp_x >= 0) check("xfer_count", xfers - x0, exp_x);
  endtask

  task automatic run_scan(input logic [N*W-1:0] b, input bit mode, input int exp_cyc, input int exp_x);
    int x0, d0, cnt;
    x0 = xfers;
    d0 = done_cnt;
    @(posedge C); #1;
    bank_q = b;
    changed_only = mode;
    start = 1'b1;
    model_scan(b, mode);
    @(posedge C); #1;
    start = 1'b0;
    wait_done(cnt);
    if (exp_cyc > 0) check("done_cycle", cnt, exp_cyc);
    end_checks(x0, d0, exp_x);
  endtask

  // Monitor: compare every transfer against the queue and check stalled words stay put.
  initial begin
    logic [AW+W-1:0] e;
    forever begin
      @(negedge C);
      if (Clr) begin
        hold_chk = 1'b0;
      end else begin
        if (hold_chk) begin
          check("hold_valid", valid, 1);
          check("hold_word", {addr_out, data_out}, prev_w);
        end
        if (valid && ready && CE) begin
          xfers++;
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL extra_word: got %0h expected none", {addr_out, data_out});
          end else begin
            e = exp_q.pop_front();
            check("word", {addr_out, data_out}, e);
          end
        end
        hold_chk = valid && !(ready && CE);
        prev_w = {addr_out, data_out};
        if (done && CE) done_cnt++;
      end
    end
  end

  // Consumer ready pattern: always, 1-0-0 repeating, or random.
  initial begin
    forever begin
      @(posedge C); #1;
      case (ready_mode)
        0: ready = 1'b1;
        1: ready = ((rcyc % 3) == 0);
        default: ready = 1'($urandom_range(0, 1));
      endcase
      rcyc++;
    end
  end

  // Clock-enable driver: on request, freeze the block for three edges while word 1 is offered.
  initial begin
    CE = 1'b1;
    forever begin
      @(posedge C); #1;
      if (ce_plan && valid && addr_out == 2'd1) begin
        CE = 1'b0;
        repeat (3) @(posedge C);
        #1;
        CE = 1'b1;
        ce_plan = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int x0, d0, cnt;
    logic [31:0] r;
    logic [N*W-1:0] b;
    bit m;

    model_reset();
    repeat (3) @(posedge C);
    #1;
    check_reset_outputs("reset");
    Clr = 1'b0;

    // Basic scan, ready held high.
    ready_mode = 0;
    run_scan(16'h61FA, 1'b0, 6, 4);

    // Same scan with stalling consumer.
    ready_mode = 1;
    run_scan(16'h61FA, 1'b0, -1, 4);

    // Changed-only after only r1 changed.
    ready_mode = 0;
    run_scan(16'h617A, 1'b1, 6, 1);

    // Clock-enable stall on word 1.
    ce_plan = 1'b1;
    run_scan(16'h2B4D, 1'b0, 9, 4);
    check("ce_stall_taken", ce_plan, 0);

    // Reset in the middle of word 2.
    @(posedge C); #1;
    bank_q = 16'h61FA;
    changed_only = 1'b0;
    start = 1'b1;
    model_scan(16'h61FA, 1'b0);
    @(posedge C); #1;
    start = 1'b0;
    cnt = 0;
    while (!(valid && addr_out == 2'd2) && cnt < 50) begin
      @(posedge C); #1;
      cnt++;
    end
    check("clr_reach_w2", (valid && addr_out == 2'd2), 1);
    check("busy_mid", busy, 1);
    Clr = 1'b1;
    model_reset();
    @(posedge C); #1;
    Clr = 1'b0;
    check_reset_outputs("midclr");
    run_scan(16'h0000, 1'b1, 6, 4);

    // Start while busy and bank change after snapshot are both ignored.
    x0 = xfers;
    d0 = done_cnt;
    @(posedge C); #1;
    bank_q = 16'h3C5A;
    changed_only = 1'b0;
    start = 1'b1;
    model_scan(16'h3C5A, 1'b0);
    @(posedge C); #1;
    start = 1'b0;
    @(posedge C); #1;
    start = 1'b1;
    bank_q = 16'hFFFF;
    @(posedge C); #1;
    start = 1'b0;
    wait_done(cnt);
    end_checks(x0, d0, 4);

    // Random scans with random ready; small bit flips keep some words unchanged.
    ready_mode = 2;
    b = 16'h3C5A;
    for (int k = 0; k < 10; k++) begin
      r = $urandom() & $urandom() & $urandom();
      b = b ^ r[N*W-1:0];
      m = 1'($urandom_range(0, 1));
      run_scan(b, m, -1, -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
